// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for the word-wide data memory.
// Sequences MemRead/MemWrite from flops, does read-modify-write for byte/half
// stores, and returns aligned, extended load data over a valid/ready handshake.
// Optional build macro: LSU_MISALIGN_TRAP_EN (fault misaligned / reserved-size requests).
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_input,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] mem_data_Out
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, next_state;
  logic        write_q, signed_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q, rdata_q;
  logic [1:0]  eff_size;
  logic        fault;
  logic        word_store;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext, merged;

  // The reserved size code behaves as a word access whenever it is not trapped.
  assign eff_size   = (req_size == 2'b11) ? 2'b10 : req_size;
  assign word_store = req_write && (eff_size == 2'b10);

`ifdef LSU_MISALIGN_TRAP_EN
  assign fault = (req_size == 2'b11) ||
                 ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign fault = 1'b0;
`endif

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;

  // State register; reset drops any in-flight access and pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode: faults skip memory, word stores skip the read.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (fault)           next_state = RESP;
          else if (word_store) next_state = WR;
          else                 next_state = RD;
        end
      end
      RD:      next_state = write_q ? WR : RESP;
      WR:      next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Lane selection for loads and the lane merge for sub-word stores.
  always_comb begin
    byte_sel = mem_data_Out[{lane_q, 3'b000} +: 8];
    half_sel = mem_data_Out[{lane_q[1], 4'b0000} +: 16];
    load_ext = mem_data_Out;
    merged   = mem_data_Out;
    case (size_q)
      2'b00: begin
        load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        load_ext = mem_data_Out;
        merged   = wdata_q;
      end
    endcase
  end

  // Request capture, memory strobes and response data, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= 2'b00;
      lane_q         <= 2'b00;
      wdata_q        <= '0;
      rdata_q        <= '0;
      mem_address    <= '0;
      mem_data_input <= '0;
      MemRead        <= 1'b0;
      MemWrite       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            signed_q    <= req_signed;
            size_q      <= eff_size;
            lane_q      <= req_addr[1:0];
            wdata_q     <= req_wdata;
            rdata_q     <= '0;
            mem_address <= {req_addr[31:2], 2'b00};
            if (!fault) begin
              if (word_store) begin
                mem_data_input <= req_wdata;
                MemWrite       <= 1'b1;
              end else begin
                MemRead <= 1'b1;
              end
            end
          end
        end
        RD: begin
          MemRead <= 1'b0;
          if (write_q) begin
            mem_data_input <= merged;
            MemWrite       <= 1'b1;
          end else begin
            rdata_q <= load_ext;
          end
        end
        WR: MemWrite <= 1'b0;
        RESP: if (resp_ready) rdata_q <= '0;
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  // Fault flag is set at acceptance and cleared when the response is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           err_q <= 1'b0;
    else if ((state == IDLE) && req_valid) err_q <= fault;
    else if ((state == RESP) && resp_ready) err_q <= 1'b0;
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the CPU's data memory. Accepts one load/store request at a time from the MEM stage and sequences the data memory's MemRead/MemWrite, address and write-data inputs from registers. Byte and halfword stores use read-modify-write over the word-wide memory. Returns aligned, sign- or zero-extended load data through a valid/ready response handshake.

## Interface
- No parameters; data/address width fixed at 32.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  load sign-extends when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  request faulted; no memory access was made
- mem_address  out  32  to data memory address; always word-aligned (bits [1:0] = 0)
- mem_data_input  out  32  to data memory write data
- MemRead  out  1  to data memory
- MemWrite  out  1  to data memory
- mem_data_Out  in  32  from data memory; combinational read

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch the request, set mem_address = {req_addr[31:2],2'b00}, and go to:
  - RESP with err=1 on a fault;
  - WR for a word store (mem_data_input = req_wdata);
  - RD for any load or sub-word store.
- RD: MemRead=1 for exactly one cycle; capture mem_data_Out at its end. Load -> RESP; sub-word store -> WR with the merged word.
- WR: MemWrite=1 for exactly one cycle -> RESP.
- RESP: resp_valid=1; outputs stable until resp_valid && resp_ready, then -> IDLE. No new request is accepted in the same cycle.
- Lanes are little-endian.
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Store merge replaces only the addressed lane with the low byte/half of req_wdata; other lanes keep the read value.
- Load extension: byte/half sign-extended when req_signed=1, else zero-extended; word passed through.
- Faults (with trap enabled): half with addr[0]=1, word with addr[1:0]!=0, size=11. A fault gives resp_err=1, resp_rdata=0, and no MemRead/MemWrite.
- MemRead and MemWrite are never high together. Both come from flops, so the level-sensitive memory sees no glitches. mem_address and mem_data_input stay stable through the whole MemWrite cycle.

## Timing
- Request accepted at edge T. Response resp_valid first high after:
  - word store, word/sub-word load: edge T+2;
  - sub-word store: edge T+3;
  - fault: edge T+1.
- Back-to-back throughput: one request per latency+1 cycles with resp_ready held high.
- Reset values:
  - state=IDLE, req_ready=1;
  - resp_valid=0, resp_rdata=0, resp_err=0;
  - MemRead=0, MemWrite=0, mem_address=0, mem_data_input=0.
- Reset asserted mid-operation (RD/WR/RESP): outputs go to reset values immediately (asynchronous). An in-flight write is abandoned and the pending response is discarded.
- req_valid while not in IDLE: ignored (req_ready=0); the requester holds it.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: faults are detected as listed above.
- LSU_MISALIGN_TRAP_EN undefined: no faults, and resp_err is tied to 0.
  - Low address bits below the access size are ignored: half uses addr[1], word uses none.
  - size=11 is treated as word.

## Test plan
- Memory word 0 = 0xA01100AB; load byte signed addr 0x0 -> resp_rdata=0xFFFFFFAB at T+2; MemRead high exactly in cycle T+1 with mem_address=0.
- Load half unsigned addr 0x2 -> 0x0000A011; load word addr 0x8 (0x21101122) -> 0x21101122, resp_err=0.
- Memory word 4 = 0x10101011; store byte 0x55 at addr 0x5 -> RD then WR, mem_data_input=0x10105511, resp_valid at T+3; a following word load of 0x4 returns 0x10105511.
- Trap enabled: load half addr 0x3 -> resp_err=1, resp_rdata=0 at T+1, MemRead/MemWrite never asserted. Trap disabled: same request returns 0xA011 from word 0.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0; a new request is accepted only after the handshake.
- Assert reset during the WR cycle of a byte store -> MemWrite drops with no clock edge, all outputs return to reset values, req_ready=1 after release.
